// File: rtl/apb_buzzer_player_pkg.sv
// Shared definitions for the APB buzzer player: register decode, bit positions,
// note field widths and the sequencer state encoding.
package buzzer_pkg;

  localparam int HALF_W = 16;
  localparam int DUR_W  = 16;

  // Register index, i.e. PADDR[3:2]
  localparam logic [1:0] REG_NOTE   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_FLUSH  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_DONE  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/apb_buzzer_player_if.sv
// APB slave bus bundle for the buzzer player (no wait states, so PREADY is an output only).
interface apb_buzzer_player_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [3:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (output PSEL, PENABLE, PWRITE, PADDR, PWDATA, input PRDATA, PREADY);
  modport slave  (input PSEL, PENABLE, PWRITE, PADDR, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/apb_buzzer_player_note_fifo.sv
// Synchronous note FIFO; rdata is registered and valid the cycle after a pop.
module note_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] rdata_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == CW'(0));
  assign full_o  = (count_q == CW'(DEPTH));
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;
  assign rdata_o = rdata_q;
  assign count_o = count_q;

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  // Pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= AW'(0);
      rptr_q  <= AW'(0);
      count_q <= CW'(0);
      rdata_q <= WIDTH'(0);
    end else if (flush_i) begin
      wptr_q  <= AW'(0);
      rptr_q  <= AW'(0);
      count_q <= CW'(0);
    end else begin
      if (push_ok) begin
        wptr_q <= wptr_q + AW'(1);
      end
      if (pop_ok) begin
        rptr_q  <= rptr_q + AW'(1);
        rdata_q <= mem_q[rptr_q];
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/apb_buzzer_player.sv
// APB note sequencer: queues {duration, half_period} words and plays them as a
// square wave on buzzer, flagging done/BuzzerINT when the queue drains.
module apb_buzzer_player
  import buzzer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  apb_buzzer_player_if.slave  apb,
  output logic                buzzer,
  output logic                BuzzerINT
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic              wr_en, note_wr, ctrl_wr, stat_wr, flush;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_rdata;
  logic              en_q, en_d, irq_en_q, irq_en_d, ovf_q, ovf_d, done_q, done_d, int_q;
  state_e            state_q;
  logic [HALF_W-1:0] half_q, tone_q;
  logic [DUR_W-1:0]  dur_q;
  logic [PW-1:0]     presc_q;
  logic              buzzer_q;
  logic              presc_wrap, final_tick, done_set;
  logic [31:0]       status_w, prdata;
  logic              unused_addr;

  assign wr_en     = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign note_wr   = wr_en & (apb.PADDR[3:2] == REG_NOTE);
  assign ctrl_wr   = wr_en & (apb.PADDR[3:2] == REG_CTRL);
  assign stat_wr   = wr_en & (apb.PADDR[3:2] == REG_STATUS);
  assign flush     = ctrl_wr & apb.PWDATA[CTRL_FLUSH];
  assign fifo_push = note_wr & ~fifo_full;
  assign unused_addr = ^apb.PADDR[1:0];

  // dur_q is never 0 in PLAY, so the last prescaler wrap is the one seen with dur_q == 1
  assign presc_wrap = (presc_q == PRESC_MAX);
  assign final_tick = (state_q == S_PLAY) & presc_wrap & (dur_q == DUR_W'(1));
  assign fifo_pop   = ~flush & en_q & ~fifo_empty & ((state_q == S_IDLE) | final_tick);
  assign done_set   = ~flush & en_q & fifo_empty & final_tick;

  note_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .flush_i (flush),
    .wdata_i (apb.PWDATA),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  // Control and sticky status next-state; a set beats a same-cycle clear
  always_comb begin
    en_d     = ctrl_wr ? apb.PWDATA[CTRL_EN] : en_q;
    irq_en_d = ctrl_wr ? apb.PWDATA[CTRL_IRQ_EN] : irq_en_q;
    ovf_d    = (note_wr & fifo_full) | (ovf_q & ~(stat_wr & apb.PWDATA[ST_OVF]));
    done_d   = done_set | (done_q & ~(stat_wr & apb.PWDATA[ST_DONE]));
  end

  // Control/status registers and the registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      int_q    <= 1'b0;
    end else begin
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      done_q   <= done_d;
      int_q    <= irq_en_d & done_d;
    end
  end

  // Sequencer: flush and a dropped enable both abort straight to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      half_q   <= HALF_W'(0);
      dur_q    <= DUR_W'(0);
      tone_q   <= HALF_W'(0);
      presc_q  <= PW'(0);
      buzzer_q <= 1'b0;
    end else if (flush || (!en_q && state_q != S_IDLE)) begin
      state_q  <= S_IDLE;
      buzzer_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          buzzer_q <= 1'b0;
          if (fifo_pop) begin
            state_q <= S_LOAD;
          end
        end
        S_LOAD: begin
          half_q   <= fifo_rdata[HALF_W-1:0];
          dur_q    <= fifo_rdata[31:HALF_W];
          tone_q   <= HALF_W'(0);
          presc_q  <= PW'(0);
          buzzer_q <= 1'b0;
          state_q  <= (fifo_rdata[31:HALF_W] == DUR_W'(0)) ? S_IDLE : S_PLAY;
        end
        S_PLAY: begin
          if (final_tick) begin
            buzzer_q <= 1'b0;
            state_q  <= fifo_pop ? S_LOAD : S_IDLE;
          end else begin
            if (presc_wrap) begin
              presc_q <= PW'(0);
              dur_q   <= dur_q - DUR_W'(1);
            end else begin
              presc_q <= presc_q + PW'(1);
            end
            if (half_q == HALF_W'(0)) begin
              buzzer_q <= 1'b0;
              tone_q   <= HALF_W'(0);
            end else if (tone_q + HALF_W'(1) == half_q) begin
              buzzer_q <= ~buzzer_q;
              tone_q   <= HALF_W'(0);
            end else begin
              tone_q <= tone_q + HALF_W'(1);
            end
          end
        end
        default: begin
          state_q  <= S_IDLE;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  // Read mux, combinational from PADDR
  always_comb begin
    status_w            = 32'd0;
    status_w[ST_BUSY]   = (state_q != S_IDLE);
    status_w[ST_EMPTY]  = fifo_empty;
    status_w[ST_FULL]   = fifo_full;
    status_w[ST_OVF]    = ovf_q;
    status_w[ST_DONE]   = done_q;
    status_w[11:8]      = 4'(fifo_count);
    prdata              = 32'd0;
    case (apb.PADDR[3:2])
      REG_CTRL: begin
        prdata[CTRL_EN]     = en_q;
        prdata[CTRL_IRQ_EN] = irq_en_q;
      end
      REG_STATUS: prdata = status_w;
      default:    prdata = 32'd0;
    endcase
  end

  assign apb.PRDATA = prdata;
  assign apb.PREADY = 1'b1;
  assign buzzer     = buzzer_q;
  assign BuzzerINT  = int_q;

endmodule

// File: tb/tb_apb_buzzer_player.sv
// Bench for apb_buzzer_player: directed APB scenarios, a queue-based reference
// model checked every cycle, and hand-computed trace expectations.
module tb_apb_buzzer_player;

  localparam int DEPTH = 8;
  localparam int TICK  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic buzzer, buzzer_int;

  apb_buzzer_player_if bus();

  apb_buzzer_player #(.DEPTH(DEPTH), .TICK_DIV(TICK)) dut (
    .clk       (clk),
    .rst       (rst),
    .apb       (bus),
    .buzzer    (buzzer),
    .BuzzerINT (buzzer_int)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: pending notes in a queue, current note timed by elapsed PLAY cycles
  logic [31:0] mq[$];
  logic [31:0] cur;
  int          ph;       // 0 idle, 1 load, 2 play
  int          el;
  logic        m_en, m_irq, m_ovf, m_done;
  bit          m_valid = 0;
  bit          m_wr, m_fl, m_full0, m_set_done, m_set_ovf;
  int          m_idx;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      ph = 0; el = 0; cur = 32'd0;
      m_en = 1'b0; m_irq = 1'b0; m_ovf = 1'b0; m_done = 1'b0;
      m_valid = 1;
    end else begin
      m_wr       = bus.PSEL && bus.PENABLE && bus.PWRITE;
      m_idx      = int'(bus.PADDR[3:2]);
      m_fl       = m_wr && m_idx == 1 && bus.PWDATA[1];
      m_full0    = (mq.size() == DEPTH);
      m_set_done = 0;
      m_set_ovf  = 0;
      if (m_fl) begin
        mq.delete();
        ph = 0;
      end else if (!m_en && ph != 0) begin
        ph = 0;
      end else if (ph == 0) begin
        if (m_en && mq.size() > 0) begin
          cur = mq.pop_front();
          ph = 1;
        end
      end else if (ph == 1) begin
        ph = (cur[31:16] == 16'd0) ? 0 : 2;
        el = 0;
      end else begin
        el++;
        if (el == int'(cur[31:16]) * TICK) begin
          if (m_en && mq.size() > 0) begin
            cur = mq.pop_front();
            ph = 1;
          end else begin
            ph = 0;
            m_set_done = 1;
          end
        end
      end
      if (m_wr && m_idx == 0) begin
        if (m_full0) m_set_ovf = 1;
        else mq.push_back(bus.PWDATA);
      end
      if (m_wr && m_idx == 2) begin
        if (bus.PWDATA[3]) m_ovf = 1'b0;
        if (bus.PWDATA[4]) m_done = 1'b0;
      end
      if (m_set_ovf) m_ovf = 1'b1;
      if (m_set_done) m_done = 1'b1;
      if (m_wr && m_idx == 1) begin
        m_en  = bus.PWDATA[0];
        m_irq = bus.PWDATA[2];
      end
    end
  end

  // Every-cycle comparison against the model
  logic        exp_bz;
  logic [31:0] exp_rd;
  int          h;
  always @(negedge clk) begin
    if (m_valid) begin
      h = int'(cur[15:0]);
      exp_bz = (ph == 2 && h != 0) ? ((el / h) % 2 == 1) : 1'b0;
      case (int'(bus.PADDR[3:2]))
        1: exp_rd = {29'd0, m_irq, 1'b0, m_en};
        2: exp_rd = {20'd0, 4'(mq.size()), 3'd0, m_done, m_ovf,
                     mq.size() == DEPTH, mq.size() == 0, ph != 0};
        default: exp_rd = 32'd0;
      endcase
      check("model_buzzer", {31'd0, buzzer}, {31'd0, exp_bz});
      check("model_int", {31'd0, buzzer_int}, {31'd0, m_irq & m_done});
      check("model_prdata", bus.PRDATA, exp_rd);
      check("pready", {31'd0, bus.PREADY}, 32'd1);
    end
  end

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge clk); #1 bus.PENABLE = 1'b1;
    @(posedge clk); #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h8;
  endtask

  // Capture n cycles of buzzer, busy, done and BuzzerINT (PADDR parked on STATUS)
  task automatic sample(input int n, output logic [31:0] bz, output logic [31:0] by,
                        output logic [31:0] dn, output logic [31:0] it);
    bz = 32'd0; by = 32'd0; dn = 32'd0; it = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bz[i] = buzzer;
      by[i] = bus.PRDATA[0];
      dn[i] = bus.PRDATA[4];
      it[i] = buzzer_int;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] bz, by, dn, it;
  int          rises, done_at;
  logic        prev;

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 4'h8; bus.PWDATA = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_status", bus.PRDATA, 32'h0000_0002);
    check("reset_buzzer", {31'd0, buzzer}, 32'd0);

    // Reset in the middle of a note
    apb_write(4'h4, 32'h5);
    apb_write(4'h0, 32'h0005_0003);
    apb_write(4'h0, 32'h0005_0003);
    sample(4, bz, by, dn, it);
    check("pre_reset_busy", {31'd0, by[3]}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midplay_reset_status", bus.PRDATA, 32'h0000_0002);
    check("midplay_reset_buzzer", {31'd0, buzzer}, 32'd0);
    bus.PADDR = 4'h4;
    @(negedge clk);
    check("midplay_reset_ctrl", bus.PRDATA, 32'd0);
    bus.PADDR = 4'h8;

    // Single tone, half 3 / duration 2 ticks
    apb_write(4'h4, 32'h5);
    apb_write(4'h0, 32'h0002_0003);
    sample(12, bz, by, dn, it);
    check("tone_buzzer_trace", bz, 32'h0000_00E0);
    check("tone_busy_trace", by, 32'h0000_03FE);
    check("tone_done_trace", dn, 32'h0000_0C00);
    check("tone_int_trace", it, 32'h0000_0C00);
    apb_write(4'h8, 32'h10);
    @(negedge clk);
    check("done_clear_int", {31'd0, buzzer_int}, 32'd0);
    check("done_clear_status", bus.PRDATA, 32'h0000_0002);

    // Overfill with playback disabled, then drain
    apb_write(4'h4, 32'h0);
    for (int i = 0; i < 9; i++) apb_write(4'h0, 32'h0001_0001);
    @(negedge clk);
    check("overfill_status", bus.PRDATA, 32'h0000_080C);
    apb_write(4'h4, 32'h1);
    rises = 0; prev = 1'b0; done_at = -1;
    for (int i = 0; i < 80 && done_at < 0; i++) begin
      @(negedge clk);
      if (buzzer && !prev) rises++;
      prev = buzzer;
      if (bus.PRDATA[4]) done_at = i;
    end
    check("burst_done_cycle", done_at, 41);
    check("burst_rises", rises, 16);
    apb_write(4'h8, 32'h18);

    // Rest note
    apb_write(4'h0, 32'h0003_0000);
    sample(16, bz, by, dn, it);
    check("rest_buzzer_trace", bz, 32'd0);
    check("rest_busy_trace", by, 32'h0000_3FFE);
    check("rest_done_trace", dn, 32'h0000_C000);
    apb_write(4'h8, 32'h10);

    // Zero-duration note skipped, then a one-tick note
    apb_write(4'h0, 32'h0000_0005);
    apb_write(4'h0, 32'h0001_0002);
    sample(8, bz, by, dn, it);
    check("skip_busy_trace", by, 32'h0000_003E);
    check("skip_buzzer_trace", bz, 32'h0000_0030);
    check("skip_done_trace", dn, 32'h0000_00C0);
    apb_write(4'h8, 32'h10);

    // Enable dropped mid-note
    apb_write(4'h0, 32'h0005_0002);
    apb_write(4'h4, 32'h0);
    @(negedge clk);
    check("en_drop_still_busy", {31'd0, bus.PRDATA[0]}, 32'd1);
    @(negedge clk);
    check("en_drop_status", bus.PRDATA, 32'h0000_0002);
    check("en_drop_buzzer", {31'd0, buzzer}, 32'd0);

    // Flush with three notes queued behind the playing one
    apb_write(4'h4, 32'h1);
    for (int i = 0; i < 4; i++) apb_write(4'h0, 32'h0005_0002);
    @(negedge clk);
    check("pre_flush_status", bus.PRDATA, 32'h0000_0301);
    apb_write(4'h4, 32'h3);
    @(negedge clk);
    check("flush_status", bus.PRDATA, 32'h0000_0002);
    check("flush_buzzer", {31'd0, buzzer}, 32'd0);
    bus.PADDR = 4'h4;
    @(negedge clk);
    check("flush_ctrl_readback", bus.PRDATA, 32'h0000_0001);
    bus.PADDR = 4'h0;
    @(negedge clk);
    check("note_reads_zero", bus.PRDATA, 32'd0);
    bus.PADDR = 4'h8;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_buzzer_player.md
# apb_buzzer_player

APB-writable note sequencer driving the SoC buzzer; the output-direction counterpart of the keypad scanner peripheral. Software pushes {half-period, duration} note words into an internal FIFO. The block plays them back-to-back as a square wave on `buzzer`. It raises `BuzzerINT` when the queue has drained.

## Interface
Parameters:
- DEPTH, 8, note FIFO entries; must be a power of 2, at least 2.
- TICK_DIV, 50000, clk cycles per duration tick (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; synchronous and active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  APB write strobe.
- PADDR  in  4  byte address; bits [3:2] decoded.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data; combinational from PADDR.
- PREADY  out  1  tied 1; no wait states.
- buzzer  out  1  square-wave output.
- BuzzerINT  out  1  level interrupt.

## Operation
- A write takes effect when PSEL & PENABLE & PWRITE are all high.
- Register map:
  - 0x0 NOTE (write-only, reads 0).
    - [15:0] half_period in clk cycles; 0 = rest.
    - [31:16] duration in ticks.
    - A write pushes one note. If the FIFO is full, the note is dropped and the sticky `ovf` flag is set; this holds even if a pop happens in the same cycle.
  - 0x4 CTRL (read/write).
    - bit0 `en`.
    - bit1 `flush`: write-1, self-clearing, reads 0.
    - bit2 `irq_en`.
  - 0x8 STATUS.
    - bit0 `busy` (state ≠ IDLE).
    - bit1 `empty`.
    - bit2 `full`.
    - bit3 `ovf`, sticky.
    - bit4 `done`, sticky.
    - [11:8] `count`.
    - Writing 1 to bit3 or bit4 clears that flag.
  - 0xC reads 0.
- FSM states: IDLE, LOAD, PLAY.
  - IDLE: buzzer = 0. If `en` and the FIFO is non-empty, pop and go to LOAD.
  - LOAD: latch the popped note and clear the tone counter, prescaler and buzzer.
    - duration = 0: the note is discarded; go to IDLE.
    - Otherwise go to PLAY.
  - PLAY:
    - Tone counter: counts clk cycles and toggles `buzzer` on reaching half_period, then restarts. For a rest note, buzzer holds 0.
    - Prescaler: counts to TICK_DIV; each wrap decrements the remaining duration.
    - When the remaining duration reaches 0:
      - FIFO non-empty and `en`: pop and go to LOAD.
      - Otherwise: go to IDLE and set `done`.
- `en` cleared during LOAD or PLAY: go to IDLE next cycle with buzzer = 0. The current note is discarded; FIFO contents are kept.
- `flush`: empties the FIFO and aborts the current note to IDLE. `done` is not set.
- A push and a pop in the same cycle leave `count` unchanged.
- BuzzerINT = irq_en & done.
- Reset values:
  - buzzer = 0, BuzzerINT = 0, PRDATA follows PADDR.
  - CTRL = 0, ovf = done = 0.
  - FIFO empty, state IDLE.

## Timing
- A NOTE write in cycle N, with `en` = 1 and state IDLE: pop at edge N+1, LOAD in N+2, PLAY from N+3.
- First buzzer toggle: half_period cycles after PLAY entry.
- A note occupies exactly duration × TICK_DIV cycles in PLAY, plus 1 LOAD cycle.
- Back-to-back notes have a 1-cycle LOAD gap with buzzer = 0.
- `done` and BuzzerINT assert the cycle after the final tick.
- CTRL and STATUS updates are visible on PRDATA the cycle after the write.

## Structure
- Shared package `buzzer_pkg` holds:
  - Register offsets and CTRL/STATUS bit indices.
  - FSM state encoding (IDLE/LOAD/PLAY).
  - Note field widths (16/16).
- Sub-module `note_fifo`: synchronous FIFO with DEPTH × 32 bits.
  - Ports: push, pop, flush, wdata, rdata, empty, full, count.
  - Registered rdata, valid the cycle after pop.
- The top level holds APB decode, CTRL/STATUS, FSM, and the tone and tick counters.

## Test plan
All scenarios use TICK_DIV = 4.
- Reset mid-PLAY with rst high for 1 cycle → buzzer = 0, state IDLE, FIFO empty, CTRL = 0.
- en = 1, write NOTE 0x0002_0003 →
  - buzzer toggles every 3 cycles for exactly 8 PLAY cycles.
  - done = 1 the cycle after.
  - With irq_en = 1, BuzzerINT = 1.
  - Writing STATUS 0x10 clears it.
- Push 9 notes with en = 0 →
  - STATUS full = 1, count = 8, ovf = 1.
  - Set en: exactly 8 notes play, each separated by a 1-cycle buzzer-low gap.
- Write NOTE 0x0003_0000 (rest) → buzzer stays 0 for 12 cycles; busy = 1 throughout.
- Write NOTE 0x0000_0005 (duration 0) followed by 0x0001_0002 → the first note is skipped via LOAD→IDLE; the second plays 4 cycles.
- Flush mid-note with 3 notes queued → next cycle: IDLE, empty = 1, buzzer = 0, done = 0.
